// File: rtl/uart_comm.sv
`default_nettype none
// ============================================================================
// Module : uart_comm
// Brief  : 8N1 UART endpoint with flag/ack byte handshakes and TX/RX FIFOs.
// Rev    : 1.0
// ============================================================================
module uart_comm #(
  parameter int ID        = 0,
  parameter int BAUDRATE  = 115200,
  parameter int CLOCKRATE = 100000000,
  parameter int FIFO_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send_flag,
  input  logic [7:0] send_data,
  input  logic       recv_flag,
  output logic [7:0] recv_data,
  output logic       send_ack,
  output logic       recv_ack,
  output logic       sendable,
  output logic       recvable,
  output logic       Tx,
  input  logic       Rx
);

  localparam int c_DIV   = CLOCKRATE / BAUDRATE;
  localparam int c_CW    = $clog2(c_DIV);
  localparam int c_DEPTH = 1 << FIFO_LOG2;

  typedef logic [c_CW-1:0]      div_t;
  typedef logic [FIFO_LOG2:0]   cnt_t;
  typedef logic [FIFO_LOG2-1:0] ptr_t;

  localparam div_t c_BIT_LAST  = div_t'(c_DIV - 1);
  localparam div_t c_HALF_LAST = div_t'(c_DIV / 2 - 1);
  localparam cnt_t c_FULL      = cnt_t'(c_DEPTH);

  // ID only tags simulation messages; it has no hardware meaning.
  logic [31:0] unused_id;
  assign unused_id = ID;

  // --------------------------------------------------------------------------
  // TX FIFO
  // --------------------------------------------------------------------------
  logic [7:0] tx_mem_q [c_DEPTH];
  ptr_t       tx_wr_q, tx_rd_q;
  cnt_t       tx_cnt_q, tx_cnt_d;
  logic       send_ack_q, sendable_q;
  logic       w_tx_push, w_tx_pop;

  assign w_tx_push = send_flag && sendable_q && !send_ack_q;

  always_comb begin
    tx_cnt_d = tx_cnt_q;
    case ({w_tx_push, w_tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + cnt_t'(1);
      2'b01:   tx_cnt_d = tx_cnt_q - cnt_t'(1);
      default: tx_cnt_d = tx_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_tx_push) tx_mem_q[tx_wr_q] <= send_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      tx_cnt_q   <= '0;
      send_ack_q <= 1'b0;
      sendable_q <= 1'b1;
    end else begin
      if (w_tx_push) tx_wr_q <= tx_wr_q + ptr_t'(1);
      if (w_tx_pop)  tx_rd_q <= tx_rd_q + ptr_t'(1);
      tx_cnt_q   <= tx_cnt_d;
      send_ack_q <= w_tx_push;
      sendable_q <= (tx_cnt_d != c_FULL);
    end
  end

  // --------------------------------------------------------------------------
  // TX engine
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  tx_state_e  tx_state_q;
  div_t       tx_div_q;
  logic [2:0] tx_bit_q;
  logic [7:0] tx_sh_q;
  logic       tx_q;
  logic       w_tx_tick;

  assign w_tx_tick = (tx_div_q == c_BIT_LAST);
  // A new byte is taken either from idle or straight out of a finishing stop bit.
  assign w_tx_pop  = (tx_cnt_q != '0) &&
                     ((tx_state_q == TX_IDLE) || ((tx_state_q == TX_STOP) && w_tx_tick));

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_div_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (w_tx_pop) begin
            tx_sh_q    <= tx_mem_q[tx_rd_q];
            tx_q       <= 1'b0;
            tx_div_q   <= '0;
            tx_state_q <= TX_START;
          end
        end
        TX_START: begin
          if (w_tx_tick) begin
            tx_div_q   <= '0;
            tx_q       <= tx_sh_q[0];
            tx_sh_q    <= {1'b0, tx_sh_q[7:1]};
            tx_bit_q   <= '0;
            tx_state_q <= TX_DATA;
          end else begin
            tx_div_q <= tx_div_q + div_t'(1);
          end
        end
        TX_DATA: begin
          if (w_tx_tick) begin
            tx_div_q <= '0;
            if (tx_bit_q == 3'd7) begin
              tx_q       <= 1'b1;
              tx_state_q <= TX_STOP;
            end else begin
              tx_q     <= tx_sh_q[0];
              tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
              tx_bit_q <= tx_bit_q + 3'd1;
            end
          end else begin
            tx_div_q <= tx_div_q + div_t'(1);
          end
        end
        TX_STOP: begin
          if (w_tx_tick) begin
            tx_div_q <= '0;
            if (w_tx_pop) begin
              tx_sh_q    <= tx_mem_q[tx_rd_q];
              tx_q       <= 1'b0;
              tx_state_q <= TX_START;
            end else begin
              tx_state_q <= TX_IDLE;
            end
          end else begin
            tx_div_q <= tx_div_q + div_t'(1);
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // RX engine
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_e;

  rx_state_e  rx_state_q;
  logic [1:0] rx_sync_q;
  div_t       rx_div_q;
  logic [2:0] rx_bit_q;
  logic [7:0] rx_sh_q;
  logic       w_rx_line, w_rx_tick;

  assign w_rx_line = rx_sync_q[1];
  assign w_rx_tick = (rx_div_q == c_BIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync_q  <= 2'b11;
      rx_state_q <= RX_IDLE;
      rx_div_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
    end else begin
      rx_sync_q <= {rx_sync_q[0], Rx};
      case (rx_state_q)
        RX_IDLE: begin
          if (!w_rx_line) begin
            rx_div_q   <= '0;
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          // Re-check at mid start bit so short low glitches are ignored.
          if (rx_div_q == c_HALF_LAST) begin
            rx_div_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= w_rx_line ? RX_IDLE : RX_DATA;
          end else begin
            rx_div_q <= rx_div_q + div_t'(1);
          end
        end
        RX_DATA: begin
          if (w_rx_tick) begin
            rx_div_q <= '0;
            rx_sh_q  <= {w_rx_line, rx_sh_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
            else                  rx_bit_q   <= rx_bit_q + 3'd1;
          end else begin
            rx_div_q <= rx_div_q + div_t'(1);
          end
        end
        RX_STOP: begin
          if (w_rx_tick) begin
            rx_div_q   <= '0;
            rx_state_q <= w_rx_line ? RX_IDLE : RX_BREAK;
          end else begin
            rx_div_q <= rx_div_q + div_t'(1);
          end
        end
        RX_BREAK: begin
          if (w_rx_line) rx_state_q <= RX_IDLE;
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // RX FIFO
  // --------------------------------------------------------------------------
  logic [7:0] rx_mem_q [c_DEPTH];
  ptr_t       rx_wr_q, rx_rd_q;
  cnt_t       rx_cnt_q, rx_cnt_d;
  logic       recv_ack_q, recvable_q;
  logic [7:0] recv_data_q;
  logic       w_rx_push, w_rx_pop;

  assign w_rx_pop  = recv_flag && recvable_q && !recv_ack_q;
  // A full FIFO still accepts a byte when the client pops in the same cycle.
  assign w_rx_push = (rx_state_q == RX_STOP) && w_rx_tick && w_rx_line &&
                     ((rx_cnt_q != c_FULL) || w_rx_pop);

  always_comb begin
    rx_cnt_d = rx_cnt_q;
    case ({w_rx_push, w_rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + cnt_t'(1);
      2'b01:   rx_cnt_d = rx_cnt_q - cnt_t'(1);
      default: rx_cnt_d = rx_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_rx_push) rx_mem_q[rx_wr_q] <= rx_sh_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_q     <= '0;
      rx_rd_q     <= '0;
      rx_cnt_q    <= '0;
      recv_ack_q  <= 1'b0;
      recvable_q  <= 1'b0;
      recv_data_q <= '0;
    end else begin
      if (w_rx_push) rx_wr_q <= rx_wr_q + ptr_t'(1);
      if (w_rx_pop) begin
        rx_rd_q     <= rx_rd_q + ptr_t'(1);
        recv_data_q <= rx_mem_q[rx_rd_q];
      end
      rx_cnt_q   <= rx_cnt_d;
      recv_ack_q <= w_rx_pop;
      recvable_q <= (rx_cnt_d != '0);
    end
  end

  assign send_ack  = send_ack_q;
  assign sendable  = sendable_q;
  assign recv_ack  = recv_ack_q;
  assign recvable  = recvable_q;
  assign recv_data = recv_data_q;
  assign Tx        = tx_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_comm.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_comm
// Brief  : Self-checking bench for uart_comm at DIV=16 with a queue-based model.
// Rev    : 1.0
// ============================================================================
module tb_uart_comm;

  localparam int DIV = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       send_flag = 1'b0;
  logic [7:0] send_data = 8'h00;
  logic       recv_flag = 1'b0;
  logic [7:0] recv_data;
  logic       send_ack, recv_ack, sendable, recvable;
  logic       tx_w;
  logic       loop = 1'b1;
  logic       rx_drv = 1'b1;
  logic       rx_line;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];

  assign rx_line = loop ? tx_w : rx_drv;

  uart_comm #(
    .ID       (0),
    .BAUDRATE (1),
    .CLOCKRATE(16),
    .FIFO_LOG2(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .send_flag(send_flag),
    .send_data(send_data),
    .recv_flag(recv_flag),
    .recv_data(recv_data),
    .send_ack (send_ack),
    .recv_ack (recv_ack),
    .sendable (sendable),
    .recvable (recvable),
    .Tx       (tx_w),
    .Rx       (rx_line)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line level of bit slot idx (0=start, 1..8=data LSB first, 9=stop) of an 8N1 frame.
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    int word;
    word = 512 + 2 * int'(b);
    return logic'((word >> idx) & 1);
  endfunction

  task automatic send(input logic [7:0] b);
    int n;
    send_data = b;
    send_flag = 1'b1;
    tick();
    n = 1;
    while (send_ack !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    send_flag = 1'b0;
    check("send_ack", send_ack, 1);
  endtask

  task automatic recv_expect(input string tag, input logic [7:0] exp);
    int n;
    n = 0;
    while (recvable !== 1'b1 && n < 600) begin
      tick();
      n++;
    end
    check({tag, "_avail"}, recvable, 1);
    recv_flag = 1'b1;
    tick();
    recv_flag = 1'b0;
    check({tag, "_ack"}, recv_ack, 1);
    check({tag, "_data"}, recv_data, exp);
    tick();
    check({tag, "_ackpulse"}, recv_ack, 0);
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop);
    for (int k = 0; k < 10; k++) begin
      rx_drv = (k == 9) ? stop : frame_bit(b, k);
      repeat (DIV) tick();
    end
    rx_drv = 1'b1;
  endtask

  initial begin
    logic [7:0] burst [4];
    logic       trace [640];
    logic [7:0] b;
    int nrec, idx, mism, acks, n, lows;
    bit started;

    // Reset
    rst = 1'b1;
    repeat (3) tick();
    check("rst_tx", tx_w, 1);
    check("rst_sendable", sendable, 1);
    check("rst_recvable", recvable, 0);
    check("rst_send_ack", send_ack, 0);
    check("rst_recv_ack", recv_ack, 0);
    check("rst_recv_data", recv_data, 0);
    rst = 1'b0;
    tick();

    // Single byte loopback with bit-accurate Tx trace
    send_data = 8'hA5;
    send_flag = 1'b1;
    tick();
    check("a5_ack_latency", send_ack, 1);
    send_flag = 1'b0;
    tick();
    check("a5_ack_pulse", send_ack, 0);
    for (int p = 0; p < 10 * DIV; p++) begin
      if (p % DIV == 0 || p % DIV == DIV - 1) check("a5_tx_bit", tx_w, frame_bit(8'hA5, p / DIV));
      tick();
    end
    check("a5_tx_idle", tx_w, 1);
    recv_expect("a5", 8'hA5);
    check("a5_empty", recvable, 0);

    // Burst with send_flag held high; frames must be contiguous
    burst[0] = 8'h00; burst[1] = 8'h7F; burst[2] = 8'h80; burst[3] = 8'hFF;
    idx = 0; nrec = 0; started = 1'b0;
    send_data = burst[0];
    send_flag = 1'b1;
    for (int c = 0; c < 900 && nrec < 640; c++) begin
      tick();
      if (send_ack === 1'b1) begin
        idx++;
        if (idx < 4) send_data = burst[idx];
        else         send_flag = 1'b0;
      end
      if (!started && tx_w === 1'b0) started = 1'b1;
      if (started) begin
        trace[nrec] = tx_w;
        nrec++;
      end
    end
    send_flag = 1'b0;
    check("burst_accepted", idx, 4);
    check("burst_len", nrec, 640);
    mism = 0;
    for (int j = 0; j < nrec; j++)
      if (trace[j] !== frame_bit(burst[j / 160], (j % 160) / DIV)) mism++;
    check("burst_stream", mism, 0);
    for (int k = 0; k < 4; k++) exp_q.push_back(burst[k]);
    while (exp_q.size() > 0) recv_expect("burst", exp_q.pop_front());
    check("burst_empty", recvable, 0);

    // TX FIFO full while the engine is busy, then reset mid data bit
    loop = 1'b0;
    rx_drv = 1'b1;
    send(8'($urandom_range(0, 255)));
    send(8'h00);
    for (int k = 0; k < 15; k++) send(8'($urandom_range(0, 255)));
    check("txfull_sendable", sendable, 0);
    send_data = 8'($urandom_range(0, 255));
    send_flag = 1'b1;
    acks = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (send_ack === 1'b1) acks++;
    end
    check("txfull_no_ack", acks, 0);
    n = 0;
    while (send_ack !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    send_flag = 1'b0;
    check("txfull_ack_after_frame", send_ack, 1);
    repeat (20) tick();
    check("midframe_low", tx_w, 0);
    rst = 1'b1;
    tick();
    check("midrst_tx", tx_w, 1);
    check("midrst_sendable", sendable, 1);
    tick();
    rst = 1'b0;
    lows = 0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (tx_w !== 1'b1) lows++;
    end
    check("midrst_fifo_empty", lows, 0);
    check("midrst_recvable", recvable, 0);

    // RX overflow: 17 frames, only 16 retained
    for (int k = 0; k < 17; k++) begin
      b = 8'($urandom_range(0, 255));
      if (exp_q.size() < 16) exp_q.push_back(b);
      drive_frame(b, 1'b1);
      repeat (2) tick();
    end
    repeat (2 * DIV) tick();
    while (exp_q.size() > 0) recv_expect("ovf", exp_q.pop_front());
    check("ovf_empty", recvable, 0);

    // Framing error then a valid frame
    drive_frame(8'h55, 1'b0);
    repeat (3 * DIV) tick();
    check("frameerr_drop", recvable, 0);
    drive_frame(8'h3C, 1'b1);
    repeat (2 * DIV) tick();
    recv_expect("after_frameerr", 8'h3C);
    check("frameerr_empty", recvable, 0);

    // Short low glitch on Rx
    rx_drv = 1'b0;
    repeat (3) tick();
    rx_drv = 1'b1;
    repeat (20 * DIV) tick();
    check("glitch_ignored", recvable, 0);

    // Random loopback traffic
    loop = 1'b1;
    for (int k = 0; k < 8; k++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send(b);
    end
    while (exp_q.size() > 0) recv_expect("rand", exp_q.pop_front());
    check("rand_empty", recvable, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
